tile_fifo: RTL and testbench

- Synchronous FIFO whose entries are whole SIZE x SIZE tiles of DATA_W-bit elements.
- Sits between tile producers and consumers in the TPU datapath, e.g. staging weight or activation tiles ahead of the systolic array.
- Provides a push/pop handshake with ready flags, an occupancy count, and a registered output tile.

---
 rtl/tile_fifo_pkg.sv | 14 +
 rtl/tile_fifo_mem.sv | 44 ++++
 rtl/tile_fifo.sv | 81 ++++++++
 tb/tb_tile_fifo.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/tile_fifo_pkg.sv
// Shared definitions for the tile FIFO: default element width, element type and
// the modulo-DEPTH pointer increment used by both FIFO pointers.
package tile_fifo_pkg;

  localparam int unsigned DATA_W_DEF = 8;

  typedef logic [DATA_W_DEF-1:0] elem_t;

  // Increment with wrap at depth; depth need not be a power of two.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr + 1 >= depth) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/tile_fifo_mem.sv
// DEPTH x SIZE x SIZE tile storage with one write port and a registered read port.
// Storage is not reset; only the read register is cleared.
module tile_fifo_mem
  import tile_fifo_pkg::*;
#(
  parameter int unsigned SIZE   = 2,
  parameter int unsigned DEPTH  = 3,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned PTR_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [PTR_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata [SIZE][SIZE],
  input  logic              re,
  input  logic [PTR_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata [SIZE][SIZE]
);

  logic [DATA_W-1:0] mem_q   [DEPTH][SIZE][SIZE];
  logic [DATA_W-1:0] rdata_q [SIZE][SIZE];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < SIZE; r++) begin
        for (int c = 0; c < SIZE; c++) begin
          rdata_q[r][c] <= '0;
        end
      end
    end else if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/tile_fifo.sv
// Synchronous FIFO of SIZE x SIZE tiles with push/pop handshake, occupancy count
// and a registered output tile holding the most recently popped entry.
module tile_fifo
  import tile_fifo_pkg::*;
#(
  parameter int unsigned SIZE   = 2,
  parameter int unsigned DEPTH  = 3,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  output logic                       push_rdy,
  output logic                       pop_rdy,
  output logic [$clog2(DEPTH+1)-1:0] count,
  input  logic [DATA_W-1:0]          din  [SIZE][SIZE],
  output logic [DATA_W-1:0]          dout [SIZE][SIZE]
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             push_eff, pop_eff;

  assign push_rdy = (count_q != CNT_W'(DEPTH));
  assign pop_rdy  = (count_q != '0);
  assign push_eff = push & push_rdy;
  assign pop_eff  = pop & pop_rdy;
  assign count    = count_q;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_eff) begin
      wr_ptr_d = PTR_W'(ptr_inc(32'(wr_ptr_q), DEPTH));
    end
    if (pop_eff) begin
      rd_ptr_d = PTR_W'(ptr_inc(32'(rd_ptr_q), DEPTH));
    end
    if (push_eff && !pop_eff) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop_eff && !push_eff) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Read reads pre-edge storage, so a pop at count=1 never sees a same-cycle push.
  tile_fifo_mem #(
    .SIZE   (SIZE),
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .PTR_W  (PTR_W)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (push_eff),
    .waddr (wr_ptr_q),
    .wdata (din),
    .re    (pop_eff),
    .raddr (rd_ptr_q),
    .rdata (dout)
  );

endmodule

// File: tb/tb_tile_fifo.sv
// Directed plus random stimulus for tile_fifo, checked against a queue-based model.
module tb_tile_fifo;

  localparam int SIZE   = 2;
  localparam int DEPTH  = 3;
  localparam int DATA_W = 8;
  localparam int TW     = SIZE * SIZE * DATA_W;
  localparam int CW     = $clog2(DEPTH + 1);

  typedef logic [TW-1:0] tile_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              push = 1'b0;
  logic              pop = 1'b0;
  logic              push_rdy, pop_rdy;
  logic [CW-1:0]     count;
  logic [DATA_W-1:0] din  [SIZE][SIZE];
  logic [DATA_W-1:0] dout [SIZE][SIZE];

  tile_t model_q[$];
  tile_t exp_dout;
  int    total = 0;
  int    bad = 0;

  tile_fifo #(
    .SIZE   (SIZE),
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .push_rdy (push_rdy),
    .pop_rdy  (pop_rdy),
    .count    (count),
    .din      (din),
    .dout     (dout)
  );

  always #5 clk = ~clk;

  // Element [0][0] in the low byte, [1][1] in the high byte.
  function automatic tile_t mk(input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] c, input logic [7:0] d);
    return {d, c, b, a};
  endfunction

  function automatic tile_t got_dout();
    tile_t t;
    for (int r = 0; r < SIZE; r++)
      for (int c = 0; c < SIZE; c++)
        t[(r*SIZE+c)*DATA_W +: DATA_W] = dout[r][c];
    return t;
  endfunction

  task automatic set_din(input tile_t t);
    for (int r = 0; r < SIZE; r++)
      for (int c = 0; c < SIZE; c++)
        din[r][c] = t[(r*SIZE+c)*DATA_W +: DATA_W];
  endtask

  task automatic check(input string tag);
    int    n;
    tile_t g;
    n = model_q.size();
    g = got_dout();
    total++;
    assert (count === CW'(n)) else begin
      bad++; $error("FAIL %s count got=%0d exp=%0d", tag, count, n);
    end
    total++;
    assert (push_rdy === (n != DEPTH)) else begin
      bad++; $error("FAIL %s push_rdy got=%0b exp=%0b", tag, push_rdy, (n != DEPTH));
    end
    total++;
    assert (pop_rdy === (n != 0)) else begin
      bad++; $error("FAIL %s pop_rdy got=%0b exp=%0b", tag, pop_rdy, (n != 0));
    end
    total++;
    assert (g === exp_dout) else begin
      bad++; $error("FAIL %s dout got=%h exp=%h", tag, g, exp_dout);
    end
  endtask

  // Drive one cycle of stimulus, advance the model from pre-edge occupancy, then check.
  task automatic cyc(input logic p, input logic o, input tile_t t, input string tag);
    bit can_push, can_pop;
    push = p;
    pop  = o;
    set_din(t);
    can_push = model_q.size() < DEPTH;
    can_pop  = model_q.size() != 0;
    @(posedge clk);
    #1;
    if (o && can_pop) exp_dout = model_q.pop_front();
    if (p && can_push) model_q.push_back(t);
    push = 1'b0;
    pop  = 1'b0;
    check(tag);
  endtask

  initial begin
    exp_dout = '0;
    set_din('0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset");
    repeat (10) cyc(1'b0, 1'b0, '0, "idle");

    cyc(1'b1, 1'b0, mk(8'h11, 8'h12, 8'h21, 8'h22), "push_one");
    cyc(1'b0, 1'b1, '0, "pop_one");

    cyc(1'b1, 1'b0, mk(8'h11, 8'h12, 8'h13, 8'h14), "fill1");
    cyc(1'b1, 1'b0, mk(8'h21, 8'h22, 8'h23, 8'h24), "fill2");
    cyc(1'b1, 1'b0, mk(8'h31, 8'h32, 8'h33, 8'h34), "fill3");
    cyc(1'b1, 1'b0, mk(8'hFF, 8'hFF, 8'hFF, 8'hFF), "push_full");
    repeat (3) cyc(1'b0, 1'b1, '0, "drain");
    cyc(1'b0, 1'b1, '0, "pop_empty");

    cyc(1'b1, 1'b1, mk(8'h41, 8'h42, 8'h43, 8'h44), "pushpop_empty");
    cyc(1'b1, 1'b1, mk(8'h51, 8'h52, 8'h53, 8'h54), "pushpop_c1");
    cyc(1'b1, 1'b0, mk(8'h61, 8'h62, 8'h63, 8'h64), "wrap_pre");
    for (int i = 0; i < 7; i++)
      cyc(1'b1, 1'b1, mk(8'h70 + 8'(i), 8'h80 + 8'(i), 8'h90 + 8'(i), 8'hA0 + 8'(i)),
          "wrap_overlap");
    cyc(1'b1, 1'b0, mk(8'hB1, 8'hB2, 8'hB3, 8'hB4), "to_full");
    cyc(1'b1, 1'b1, mk(8'hEE, 8'hEE, 8'hEE, 8'hEE), "pushpop_full");
    repeat (3) cyc(1'b0, 1'b1, '0, "drain_wrap");

    for (int i = 0; i < 300; i++)
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), tile_t'($urandom()), "random");

    cyc(1'b1, 1'b0, mk(8'hC1, 8'hC2, 8'hC3, 8'hC4), "pre_rst_a");
    cyc(1'b1, 1'b0, mk(8'hD1, 8'hD2, 8'hD3, 8'hD4), "pre_rst_b");
    cyc(1'b0, 1'b1, '0, "pre_rst_pop");
    push = 1'b1;
    pop  = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    model_q.delete();
    exp_dout = '0;
    check("async_rst");
    @(posedge clk);
    #1;
    check("rst_held");
    rst  = 1'b0;
    push = 1'b0;
    pop  = 1'b0;
    check("rst_release");
    for (int i = 0; i < 100; i++)
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), tile_t'($urandom()), "random2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
